// File: rtl/piso_pkg.sv
// ============================================================================
// Module      : piso_pkg
// Description : Shared types and sizing helpers for the PISO serializer slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } piso_state_t;

  // Counter must be able to represent 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bit_counter.sv
// ============================================================================
// Module      : bit_counter
// Description : Clearable up-counter that saturates at TERMINAL and flags it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_counter #(
  parameter int CNT_W    = 4,
  parameter int TERMINAL = 7
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Terminal
);

  localparam logic [CNT_W-1:0] C_TERMINAL = CNT_W'(TERMINAL);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_count <= '0;
    end else if (i_Clear) begin
      r_count <= '0;
    end else if (i_Enable && (r_count != C_TERMINAL)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_Terminal = (r_count == C_TERMINAL);

endmodule

`default_nettype wire

// File: rtl/piso_serializer.sv
// ============================================================================
// Module      : piso_serializer
// Description : Valid/ready parallel-in serial-out shifter with done pulse.
//               Define PISO_PARITY_EN to append an even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_serializer
  import piso_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   LSB_FIRST  = 1'b0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_TX_DV,
  input  logic [WIDTH-1:0] i_TX_Word,
  output logic             o_TX_Ready,
  output logic             o_TX_Serial,
  output logic             o_TX_Active,
  output logic             o_TX_Done
);

  localparam int C_CNT_W = cnt_width(WIDTH);

  piso_state_t      r_state;
  piso_state_t      w_state_next;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_load;
  logic [WIDTH-1:0] w_shift_step;
  logic             w_first_bit;
  logic             w_next_bit;
  logic             w_accept;
  logic             w_last;
  logic             w_serial_d;
  logic             w_active_d;
  logic             w_ready_d;
  logic             w_done_d;

  assign w_accept = i_TX_DV && o_TX_Ready;

  // The first bit goes straight to the output at accept, so the register
  // holds the word already advanced by one position.
  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign w_first_bit  = i_TX_Word[0];
      assign w_shift_load = {1'b0, i_TX_Word[WIDTH-1:1]};
      assign w_next_bit   = r_shift[0];
      assign w_shift_step = {1'b0, r_shift[WIDTH-1:1]};
    end else begin : g_msb_first
      assign w_first_bit  = i_TX_Word[WIDTH-1];
      assign w_shift_load = {i_TX_Word[WIDTH-2:0], 1'b0};
      assign w_next_bit   = r_shift[WIDTH-1];
      assign w_shift_step = {r_shift[WIDTH-2:0], 1'b0};
    end
  endgenerate

  bit_counter #(
    .CNT_W    (C_CNT_W),
    .TERMINAL (WIDTH - 1)
  ) u_bit_counter (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .i_Clear    (w_accept),
    .i_Enable   (r_state == SHIFT),
    .o_Terminal (w_last)
  );

`ifdef PISO_PARITY_EN
  logic r_parity;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= ^i_TX_Word;
    end
  end
`endif

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (w_last) begin
`ifdef PISO_PARITY_EN
          w_state_next = PARITY;
`else
          w_state_next = IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: w_state_next = IDLE;
`endif
      default: w_state_next = IDLE;
    endcase
  end

  // Output values are computed from the upcoming state and then registered.
  always_comb begin
    w_serial_d = IDLE_LEVEL;
    w_active_d = (w_state_next != IDLE);
    w_ready_d  = (w_state_next == IDLE);
    w_done_d   = (r_state != IDLE) && (w_state_next == IDLE);
    case (w_state_next)
      SHIFT:   w_serial_d = (r_state == IDLE) ? w_first_bit : w_next_bit;
`ifdef PISO_PARITY_EN
      PARITY:  w_serial_d = r_parity;
`endif
      default: w_serial_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_shift     <= '0;
      o_TX_Serial <= IDLE_LEVEL;
      o_TX_Ready  <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shift <= w_shift_load;
      end else if (r_state == SHIFT) begin
        r_shift <= w_shift_step;
      end
      o_TX_Serial <= w_serial_d;
      o_TX_Ready  <= w_ready_d;
      o_TX_Active <= w_active_d;
      o_TX_Done   <= w_done_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_piso_serializer.sv
// ============================================================================
// Module      : tb_piso_serializer
// Description : Randomized bench for piso_serializer (MSB-first idle-low and
//               LSB-first idle-high instances) against a cycle-sequence model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_piso_serializer;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int SEQ_N = W + 2;
`else
  localparam int SEQ_N = W + 1;
`endif
  localparam logic IDLE0 = 1'b0;
  localparam logic IDLE1 = 1'b1;

  // Expected output tuple for one clock cycle.
  typedef struct packed {
    logic ser;
    logic act;
    logic done;
    logic rdy;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         dv0 = 1'b0, dv1 = 1'b0;
  logic [W-1:0] w0 = '0, w1 = '0;
  logic         rdy0, ser0, act0, done0;
  logic         rdy1, ser1, act1, done1;

  int   errors = 0;
  int   checks = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t cur0 = {IDLE0, 1'b0, 1'b0, 1'b1};
  exp_t cur1 = {IDLE1, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_LEVEL(IDLE0)) u_msb (
    .i_Clk       (clk),
    .i_Rst_L     (rst_n),
    .i_TX_DV     (dv0),
    .i_TX_Word   (w0),
    .o_TX_Ready  (rdy0),
    .o_TX_Serial (ser0),
    .o_TX_Active (act0),
    .o_TX_Done   (done0)
  );

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_LEVEL(IDLE1)) u_lsb (
    .i_Clk       (clk),
    .i_Rst_L     (rst_n),
    .i_TX_DV     (dv1),
    .i_TX_Word   (w1),
    .o_TX_Ready  (rdy1),
    .o_TX_Serial (ser1),
    .o_TX_Active (act1),
    .o_TX_Done   (done1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Cycle i (0-based) after an accept: data bits, optional parity, then done.
  function automatic exp_t seq_at(input bit lsb, input logic idle, input logic [W-1:0] w,
                                  input int i);
    exp_t e;
    if (i < W) e = {(lsb ? w[i] : w[W-1-i]), 1'b1, 1'b0, 1'b0};
    else if (i < SEQ_N - 1) e = {^w, 1'b1, 1'b0, 1'b0};
    else e = {idle, 1'b0, 1'b1, 1'b1};
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      cur0 = {IDLE0, 1'b0, 1'b0, 1'b1};
      cur1 = {IDLE1, 1'b0, 1'b0, 1'b1};
    end else begin
      if (dv0 && cur0.rdy) for (int i = 0; i < SEQ_N; i++) q0.push_back(seq_at(1'b0, IDLE0, w0, i));
      if (dv1 && cur1.rdy) for (int i = 0; i < SEQ_N; i++) q1.push_back(seq_at(1'b1, IDLE1, w1, i));
      cur0 = (q0.size() > 0) ? q0.pop_front() : exp_t'({IDLE0, 1'b0, 1'b0, 1'b1});
      cur1 = (q1.size() > 0) ? q1.pop_front() : exp_t'({IDLE1, 1'b0, 1'b0, 1'b1});
    end
  end

  always @(negedge clk) begin
    check("msb_serial", 32'(ser0), 32'(cur0.ser));
    check("msb_active", 32'(act0), 32'(cur0.act));
    check("msb_done",   32'(done0), 32'(cur0.done));
    check("msb_ready",  32'(rdy0), 32'(cur0.rdy));
    check("lsb_serial", 32'(ser1), 32'(cur1.ser));
    check("lsb_active", 32'(act1), 32'(cur1.act));
    check("lsb_done",   32'(done1), 32'(cur1.done));
    check("lsb_ready",  32'(rdy1), 32'(cur1.rdy));
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic send0(input logic [W-1:0] w);
    dv0 = 1'b1; w0 = w; tick(); dv0 = 1'b0; w0 = W'($urandom);
  endtask

  task automatic send1(input logic [W-1:0] w);
    dv1 = 1'b1; w1 = w; tick(); dv1 = 1'b0; w1 = W'($urandom);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    for (k = 0; k < 60; k++) begin
      if (q0.size() == 0 && q1.size() == 0 && !cur0.done && !cur1.done && cur0.rdy && cur1.rdy)
        break;
      tick();
    end
    check(tag, 32'(k < 60), 32'd1);
  endtask

  initial begin
    // Reset held for three cycles, then ten idle cycles.
    tick(3);
    rst_n = 1'b1;
    tick(10);

    send0(8'hA5);
    wait_idle("wait_a5");

    // Back-to-back on the LSB-first instance: second accept in the done cycle.
    send1(8'h01);
    begin
      int k;
      for (k = 0; k < 40 && !cur1.done; k++) tick();
      check("wait_done_01", 32'(k < 40), 32'd1);
    end
    send1(8'h80);
    wait_idle("wait_b2b");

    // Valid while busy is dropped.
    send0(8'h3C);
    tick(1);
    send0(8'hFF);
    wait_idle("wait_busy");

    // Reset in the middle of a word.
    send0(8'hF0);
    tick(2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_serial", 32'(ser0), 32'(IDLE0));
    check("async_active", 32'(act0), 32'd0);
    check("async_done",   32'(done0), 32'd0);
    check("async_ready",  32'(rdy0), 32'd1);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    send0(8'h0F);
    wait_idle("wait_0f");

    send0(8'h07);
    send1(8'h03);
    wait_idle("wait_07");
    send0(8'h03);
    send1(8'h07);
    wait_idle("wait_03");

    // Random valid pulses on both instances.
    for (int c = 0; c < 400; c++) begin
      dv0 = ($urandom_range(0, 3) == 0);
      w0  = W'($urandom);
      dv1 = ($urandom_range(0, 2) == 0);
      w1  = W'($urandom);
      tick();
    end
    dv0 = 1'b0;
    dv1 = 1'b0;
    wait_idle("wait_rand");
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out shift register; the transmit end of the serial-in delay/shift chains used across the project.
- Accepts one WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock.
- Raises a one-cycle done pulse when the word has been sent.
- Sits between parallel logic (counters, FIFOs, register files) and any single-wire bit-serial link or downstream serial-in shift register.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- LSB_FIRST, 0, 0 sends bit WIDTH-1 first; 1 sends bit 0 first.
- IDLE_LEVEL, 1'b0, level driven on o_TX_Serial when not shifting.

Ports:
- i_Clk  input  1  system clock; all logic is on the rising edge.
- i_Rst_L  input  1  asynchronous active-low reset.
- i_TX_DV  input  1  input word valid.
- i_TX_Word  input  WIDTH  parallel word to send.
- o_TX_Ready  output  1  block can accept a word this cycle.
- o_TX_Serial  output  1  serial data out, registered.
- o_TX_Active  output  1  high while data bits (and the parity bit, when enabled) are on o_TX_Serial.
- o_TX_Done  output  1  one-cycle pulse after the last bit.

Behaviour:
- Reset state (asynchronous assert on i_Rst_L low; release is synchronous to i_Clk):
  - state=IDLE, shift register=0, bit counter=0.
  - o_TX_Serial=IDLE_LEVEL, o_TX_Ready=1, o_TX_Active=0, o_TX_Done=0.
- Handshake:
  - Accept occurs on a rising edge where i_TX_DV=1 and o_TX_Ready=1.
  - i_TX_Word is captured into the shift register only at the accept edge; later changes to it are ignored.
  - i_TX_DV while o_TX_Ready=0 is dropped: no queueing, no error flag.
- State IDLE:
  - o_TX_Ready=1; o_TX_Serial=IDLE_LEVEL.
  - On accept: go to SHIFT, load the word, clear the counter.
- State SHIFT:
  - o_TX_Ready=0, o_TX_Active=1.
  - Bit i of the send order is on o_TX_Serial during the i-th cycle after the accept edge (i = 1..WIDTH).
  - The shift register shifts by one each cycle, left for MSB-first, right for LSB-first.
  - The counter increments each cycle.
  - At the edge ending bit WIDTH: go to IDLE, or to PARITY when enabled.
- Return to IDLE:
  - In the first IDLE cycle after SHIFT (or PARITY), o_TX_Done=1 for exactly one cycle.
  - In that same cycle o_TX_Ready=1 and o_TX_Serial=IDLE_LEVEL.
- Latency: first bit appears 1 cycle after accept.
- Throughput: minimum spacing between accepts is WIDTH+1 cycles (WIDTH+2 with parity).
  - Back-to-back: an accept in the done cycle is legal; the next word's first bit then follows with no extra gap.
- Counter: sized $clog2(WIDTH+1); terminal count is WIDTH-1; it never wraps past that value.
- Reset mid-word: transmission is aborted immediately, outputs take reset values, and no o_TX_Done is issued.
- Outputs are all registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - Adds state PARITY after SHIFT, lasting one cycle.
  - o_TX_Serial = even parity, the XOR of the captured word; o_TX_Active stays 1.
  - The parity bit is computed at capture and held in a register.
  - o_TX_Done follows PARITY.
- Undefined: PARITY state, parity register and XOR logic are absent; SHIFT goes directly to IDLE.

Decomposition:
- Package piso_pkg holds:
  - the state enum typedef (IDLE, SHIFT, PARITY);
  - a localparam function computing counter width from WIDTH.
- One sub-module is natural: bit_counter (load-clear, enable, terminal-count flag, parameterised width). It is reusable by the matching deserializer.
- The shift register and FSM remain in the top module.

Test Plan:
- Reset then idle, WIDTH=8: hold i_Rst_L=0 for 3 cycles, release, i_TX_DV=0 for 10 cycles -> Ready=1, Serial=IDLE_LEVEL, Active=0, Done=0 throughout.
- Single word, MSB-first: accept 8'hA5 -> Serial 1,0,1,0,0,1,0,1 in cycles 1..8 after accept; Active high in exactly those 8 cycles; Done=1 in cycle 9 only.
- LSB_FIRST=1: accept 8'h01 -> Serial 1,0,0,0,0,0,0,0; then accept 8'h80 in the done cycle -> 0,0,0,0,0,0,0,1 immediately following, no idle gap.
- Busy drop: accept 8'h3C, pulse i_TX_DV with 8'hFF at cycle 3 -> output is exactly the 8'h3C bits; no second transmission; a single Done pulse.
- Reset mid-word: accept 8'hF0, drop i_Rst_L at cycle 4 -> Serial=IDLE_LEVEL asynchronously, Active=0, no Done; after release, Ready=1 and accept 8'h0F sends correctly.
- PISO_PARITY_EN defined: accept 8'h07 -> 8 data bits, then parity bit 1 in cycle 9 with Active=1; Done in cycle 10. Accept 8'h03 -> parity bit 0.
